// File: rtl/mips_controller_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes,
// funct fields, ALU operation selectors and ALU control codes.
package mips_controller_pkg;

   localparam logic [3:0] FETCH1  = 4'd0;
   localparam logic [3:0] FETCH2  = 4'd1;
   localparam logic [3:0] FETCH3  = 4'd2;
   localparam logic [3:0] FETCH4  = 4'd3;
   localparam logic [3:0] DECODE  = 4'd4;
   localparam logic [3:0] MEMADR  = 4'd5;
   localparam logic [3:0] LBRD    = 4'd6;
   localparam logic [3:0] LBWR    = 4'd7;
   localparam logic [3:0] SBWR    = 4'd8;
   localparam logic [3:0] RTYPEEX = 4'd9;
   localparam logic [3:0] RTYPEWR = 4'd10;
   localparam logic [3:0] BEQEX   = 4'd11;
   localparam logic [3:0] JEX     = 4'd12;
   localparam logic [3:0] ADDIWR  = 4'd13;

   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_controller_if.sv
// Controller <-> datapath bundle: instruction fields and zero flag in,
// register enables and mux selects out.
interface mips_controller_if;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       memread;
   logic       memwrite;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic       memtoreg;
   logic       iord;
   logic       regwrite;
   logic       regdst;
   logic [1:0] pcsource;
   logic       pcen;
   logic [3:0] irwrite;
   logic [2:0] alucont;

   modport master (
      input  op, funct, zero,
      output memread, memwrite, alusrca, alusrcb, memtoreg, iord,
             regwrite, regdst, pcsource, pcen, irwrite, alucont
   );

   modport slave (
      output op, funct, zero,
      input  memread, memwrite, alusrca, alusrcb, memtoreg, iord,
             regwrite, regdst, pcsource, pcen, irwrite, alucont
   );
endinterface

// File: rtl/mips_controller_alu_decoder.sv
// ALU control decode: fixed add/sub for address and branch work,
// funct-driven operation for R-type instructions.
module alu_decoder
   import mips_controller_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [5:0] funct,
   output logic [2:0] alucont
);

   always_comb begin
      alucont = ALU_ADD;
      case (aluop)
         ALUOP_ADD: alucont = ALU_ADD;
         ALUOP_SUB: alucont = ALU_SUB;
         default: begin
            case (funct)
               FUNCT_ADD: alucont = ALU_ADD;
               FUNCT_SUB: alucont = ALU_SUB;
               FUNCT_AND: alucont = ALU_AND;
               FUNCT_OR:  alucont = ALU_OR;
               FUNCT_SLT: alucont = ALU_SLT;
               default:   alucont = ALU_ADD;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/mips_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing a 4-byte fetch,
// decode and per-class execute/writeback states.
module mips_controller
   import mips_controller_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   mips_controller_if.master ctl
);

   logic [3:0] state, nextstate;
   logic       pcwrite, branch;
   logic [1:0] aluop;

   logic       memread, memwrite, alusrca, memtoreg, iord, regwrite, regdst;
   logic [1:0] alusrcb, pcsource;
   logic [3:0] irwrite;

   always_ff @(posedge clk) begin
      if (reset) state <= FETCH1;
      else       state <= nextstate;
   end

   always_comb begin
      nextstate = FETCH1;
      case (state)
         FETCH1: nextstate = FETCH2;
         FETCH2: nextstate = FETCH3;
         FETCH3: nextstate = FETCH4;
         FETCH4: nextstate = DECODE;
         DECODE: begin
            case (ctl.op)
               OP_LB, OP_SB, OP_ADDI: nextstate = MEMADR;
               OP_RTYPE:              nextstate = RTYPEEX;
               OP_BEQ:                nextstate = BEQEX;
               OP_J:                  nextstate = JEX;
               default:               nextstate = FETCH1;
            endcase
         end
         MEMADR: begin
            case (ctl.op)
               OP_LB:   nextstate = LBRD;
               OP_SB:   nextstate = SBWR;
               OP_ADDI: nextstate = ADDIWR;
               default: nextstate = FETCH1;
            endcase
         end
         LBRD:    nextstate = LBWR;
         RTYPEEX: nextstate = RTYPEWR;
         default: nextstate = FETCH1;
      endcase
   end

   always_comb begin
      memread  = 1'b0;
      memwrite = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      memtoreg = 1'b0;
      iord     = 1'b0;
      regwrite = 1'b0;
      regdst   = 1'b0;
      pcsource = 2'b00;
      pcwrite  = 1'b0;
      branch   = 1'b0;
      aluop    = ALUOP_ADD;
      irwrite  = '0;
      case (state)
         FETCH1, FETCH2, FETCH3, FETCH4: begin
            memread = 1'b1;
            alusrcb = 2'b01;
            pcwrite = 1'b1;
            irwrite = 4'b0001 << state[1:0];
         end
         DECODE:  alusrcb = 2'b11;
         MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         LBRD: begin
            memread = 1'b1;
            iord    = 1'b1;
         end
         LBWR: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
         end
         SBWR: begin
            memwrite = 1'b1;
            iord     = 1'b1;
         end
         RTYPEEX: begin
            alusrca = 1'b1;
            aluop   = ALUOP_FUNCT;
         end
         RTYPEWR: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
         end
         ADDIWR:  regwrite = 1'b1;
         BEQEX: begin
            alusrca  = 1'b1;
            aluop    = ALUOP_SUB;
            branch   = 1'b1;
            pcsource = 2'b01;
         end
         JEX: begin
            pcwrite  = 1'b1;
            pcsource = 2'b10;
         end
         default: ;
      endcase
   end

   alu_decoder u_alu_decoder (
      .aluop   (aluop),
      .funct   (ctl.funct),
      .alucont (ctl.alucont)
   );

   assign ctl.memread  = memread;
   assign ctl.memwrite = memwrite;
   assign ctl.alusrca  = alusrca;
   assign ctl.alusrcb  = alusrcb;
   assign ctl.memtoreg = memtoreg;
   assign ctl.iord     = iord;
   assign ctl.regwrite = regwrite;
   assign ctl.regdst   = regdst;
   assign ctl.pcsource = pcsource;
   assign ctl.irwrite  = irwrite;
   assign ctl.pcen     = pcwrite | (branch & ctl.zero);

endmodule

// File: tb/tb_mips_controller.sv
// Directed scoreboard bench for mips_controller: each stimulated cycle queues
// the hand-derived output vector, a negedge monitor pops and compares it.
module tb_mips_controller;

   logic clk = 1'b0;
   logic reset;

   mips_controller_if bus ();

   mips_controller dut (
      .clk   (clk),
      .reset (reset),
      .ctl   (bus.master)
   );

   always #5 clk = ~clk;

   // Vector layout: memread memwrite alusrca alusrcb[2] memtoreg iord
   //                regwrite regdst pcsource[2] pcen irwrite[4] alucont[3]
   logic [18:0] exp_q[$];
   string       name_q[$];
   int unsigned applied = 0;
   int unsigned miscompares = 0;

   function automatic logic [18:0] mk(
      input logic mr, input logic mw, input logic asa, input logic [1:0] asb,
      input logic mtr, input logic io, input logic rw, input logic rd,
      input logic [1:0] ps, input logic pe, input logic [3:0] ir,
      input logic [2:0] ac);
      return {mr, mw, asa, asb, mtr, io, rw, rd, ps, pe, ir, ac};
   endfunction

   localparam logic [18:0] V_F1     = {1'b1,1'b0,1'b0,2'b01,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,4'b0001,3'b010};
   localparam logic [18:0] V_F2     = {1'b1,1'b0,1'b0,2'b01,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,4'b0010,3'b010};
   localparam logic [18:0] V_F3     = {1'b1,1'b0,1'b0,2'b01,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,4'b0100,3'b010};
   localparam logic [18:0] V_F4     = {1'b1,1'b0,1'b0,2'b01,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,4'b1000,3'b010};
   localparam logic [18:0] V_DECODE = {1'b0,1'b0,1'b0,2'b11,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,4'b0000,3'b010};
   localparam logic [18:0] V_MEMADR = {1'b0,1'b0,1'b1,2'b10,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,4'b0000,3'b010};
   localparam logic [18:0] V_LBRD   = {1'b1,1'b0,1'b0,2'b00,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,4'b0000,3'b010};
   localparam logic [18:0] V_LBWR   = {1'b0,1'b0,1'b0,2'b00,1'b1,1'b0,1'b1,1'b0,2'b00,1'b0,4'b0000,3'b010};
   localparam logic [18:0] V_SBWR   = {1'b0,1'b1,1'b0,2'b00,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,4'b0000,3'b010};
   localparam logic [18:0] V_RTWR   = {1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b1,1'b1,2'b00,1'b0,4'b0000,3'b010};
   localparam logic [18:0] V_ADDIWR = {1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,4'b0000,3'b010};
   localparam logic [18:0] V_JEX    = {1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,2'b10,1'b1,4'b0000,3'b010};

   // RTYPEEX: alusrca=1, alucont from funct.
   function automatic logic [18:0] v_rtex(input logic [2:0] ac);
      return mk(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'b0000, ac);
   endfunction

   // BEQEX: subtract, pcsource=01, pcen follows zero.
   function automatic logic [18:0] v_beq(input logic pe);
      return mk(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, pe, 4'b0000, 3'b110);
   endfunction

   task automatic step(input logic [18:0] v, input string nm, input logic rst);
      reset = rst;
      exp_q.push_back(v);
      name_q.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   task automatic fetch_decode(input logic [5:0] o, input logic [5:0] f,
                               input logic z, input string tag);
      bus.op    = o;
      bus.funct = f;
      bus.zero  = z;
      step(V_F1, {tag, "_fetch1"}, 1'b0);
      step(V_F2, {tag, "_fetch2"}, 1'b0);
      step(V_F3, {tag, "_fetch3"}, 1'b0);
      step(V_F4, {tag, "_fetch4"}, 1'b0);
      step(V_DECODE, {tag, "_decode"}, 1'b0);
   endtask

   task automatic rtype(input logic [5:0] f, input logic [2:0] ac, input string tag);
      fetch_decode(6'b000000, f, 1'b0, tag);
      step(v_rtex(ac), {tag, "_rtypeex"}, 1'b0);
      step(V_RTWR, {tag, "_rtypewr"}, 1'b0);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         logic [18:0] got;
         logic [18:0] want;
         string       nm;
         got  = {bus.memread, bus.memwrite, bus.alusrca, bus.alusrcb, bus.memtoreg,
                 bus.iord, bus.regwrite, bus.regdst, bus.pcsource, bus.pcen,
                 bus.irwrite, bus.alucont};
         want = exp_q.pop_front();
         nm   = name_q.pop_front();
         applied++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %b want %b (mr mw asa asb mtr iord rw rd ps pcen ir alucont)",
                     nm, got, want);
         end
      end
   end

   initial begin
      reset     = 1'b1;
      bus.op    = 6'b111111;
      bus.funct = 6'b000000;
      bus.zero  = 1'b0;
      @(posedge clk);
      #1;
      // Two reset cycles, then an undefined opcode finishes its 5-cycle trip.
      step(V_F1, "reset_c0", 1'b1);
      step(V_F1, "reset_c1", 1'b0);
      step(V_F2, "undef0_fetch2", 1'b0);
      step(V_F3, "undef0_fetch3", 1'b0);
      step(V_F4, "undef0_fetch4", 1'b0);
      step(V_DECODE, "undef0_decode", 1'b0);

      rtype(6'b100000, 3'b010, "add");
      rtype(6'b100010, 3'b110, "sub");
      rtype(6'b100100, 3'b000, "and");
      rtype(6'b100101, 3'b001, "or");
      rtype(6'b101010, 3'b111, "slt");
      rtype(6'b000000, 3'b010, "badfunct");

      fetch_decode(6'b000100, 6'b101010, 1'b1, "beq_taken");
      step(v_beq(1'b1), "beq_taken_beqex", 1'b0);
      fetch_decode(6'b000100, 6'b101010, 1'b0, "beq_not");
      step(v_beq(1'b0), "beq_not_beqex", 1'b0);

      fetch_decode(6'b100000, 6'b000000, 1'b1, "lb");
      step(V_MEMADR, "lb_memadr", 1'b0);
      step(V_LBRD, "lb_lbrd", 1'b0);
      step(V_LBWR, "lb_lbwr", 1'b0);

      fetch_decode(6'b101000, 6'b000000, 1'b0, "sb");
      step(V_MEMADR, "sb_memadr", 1'b0);
      step(V_SBWR, "sb_sbwr", 1'b0);

      fetch_decode(6'b001000, 6'b000000, 1'b0, "addi");
      step(V_MEMADR, "addi_memadr", 1'b0);
      step(V_ADDIWR, "addi_addiwr", 1'b0);

      fetch_decode(6'b000010, 6'b000000, 1'b1, "j");
      step(V_JEX, "j_jex", 1'b0);

      fetch_decode(6'b010101, 6'b100010, 1'b1, "undef1");

      // Reset raised during MEMADR of an LB: next cycle must be FETCH1.
      fetch_decode(6'b100000, 6'b000000, 1'b0, "lbrst");
      step(V_MEMADR, "lbrst_memadr", 1'b1);
      step(V_F1, "lbrst_fetch1", 1'b0);
      step(V_F2, "lbrst_fetch2", 1'b0);

      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
